// File: rtl/sdram_work_ctrl_pkg.sv
// Shared definitions for the SDRAM operating-phase sequencer: work_state
// codes decoded by the data stage, SDRAM command encodings and small helpers.
package sdram_work_ctrl_pkg;

  // work_state codes
  localparam logic [3:0] W_IDLE   = 4'd0;
  localparam logic [3:0] W_ACTIVE = 4'd1;
  localparam logic [3:0] W_TRCD   = 4'd2;
  localparam logic [3:0] W_READ   = 4'd3;
  localparam logic [3:0] W_CL     = 4'd4;
  localparam logic [3:0] W_RD     = 4'd5;
  localparam logic [3:0] W_WRITE  = 4'd6;
  localparam logic [3:0] W_WD     = 4'd7;
  localparam logic [3:0] W_TWR    = 4'd8;
  localparam logic [3:0] W_PRE    = 4'd9;
  localparam logic [3:0] W_TRP    = 4'd10;
  localparam logic [3:0] W_AR     = 4'd11;
  localparam logic [3:0] W_TRFC   = 4'd12;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_AREF  = 4'b0001;

  // A10 set on the address bus: precharge all banks
  localparam logic [12:0] ADDR_PRE_ALL = 13'h0400;

  // Clamp a derived delay count so that a zero/negative count skips its state
  function automatic int sat0(input int v);
    return (v > 0) ? v : 0;
  endfunction

endpackage

// File: rtl/sdram_work_ctrl_if.sv
// System-side request bus plus SDRAM command pins of the work sequencer.
// master: request generator / pin consumer; slave: the sequencer itself.
interface sdram_work_ctrl_if;
  logic        init_done;
  logic        wr_req;
  logic        rd_req;
  logic [23:0] sys_addr;
  logic        wr_ack;
  logic        rd_ack;
  logic        done;
  logic        busy;
  logic [3:0]  work_state;
  logic [3:0]  sdram_cmd;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;

  modport master (
    output init_done, wr_req, rd_req, sys_addr,
    input  wr_ack, rd_ack, done, busy, work_state, sdram_cmd, sdram_ba, sdram_addr
  );

  modport slave (
    input  init_done, wr_req, rd_req, sys_addr,
    output wr_ack, rd_ack, done, busy, work_state, sdram_cmd, sdram_ba, sdram_addr
  );
endinterface

// File: rtl/sdram_work_ctrl_ref_timer.sv
// Refresh interval timer: counts while enabled, raises a pending flag on
// every wrap. ref_req also reflects the wrap cycle itself so the sequencer
// can start the refresh in the very cycle the interval expires. A wrap that
// lands on an already pending flag is coalesced into it.
module sdram_ref_timer #(
  parameter int REF_INTERVAL = 780
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic ref_req
);

  localparam int CW = (REF_INTERVAL > 2) ? $clog2(REF_INTERVAL) : 1;
  localparam logic [CW-1:0] LAST = CW'(REF_INTERVAL - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          wrap_s;

  // Next counter value and pending flag; clear wins because entering the
  // refresh consumes both the old flag and a coincident wrap.
  always_comb begin
    wrap_s = en && (cnt_q == LAST);
    if (!en) begin
      cnt_d = '0;
    end else if (wrap_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
    if (clr) begin
      pend_d = 1'b0;
    end else if (wrap_s) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  assign ref_req = pend_q | wrap_s;

  // Timer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/sdram_work_ctrl.sv
// SDRAM operating-phase command sequencer (closed-page policy).
// Arbitrates refresh > write > read in W_IDLE and walks one
// ACTIVE / READ-or-WRITE burst / PRECHARGE sequence per access.
// All pin outputs are registered together with work_state.
// Optional build macro: SDRAM_AUTO_PRE_EN (READ/WRITE with auto-precharge,
// no explicit W_PRE state).
module sdram_work_ctrl
  import sdram_work_ctrl_pkg::*;
#(
  parameter int BURST_LEN    = 4,
  parameter int T_RCD        = 2,
  parameter int CAS_LAT      = 3,
  parameter int T_WR         = 2,
  parameter int T_RP         = 2,
  parameter int T_RFC        = 7,
  parameter int REF_INTERVAL = 780
) (
  input  logic              clk_100m,
  input  logic              rst,
  sdram_work_ctrl_if.slave  bus
);

  // Cycles spent in each delay state; 0 means the state is skipped
  localparam int TRCD_N = sat0(T_RCD - 1);
  localparam int WD_N   = sat0(BURST_LEN - 1);
  localparam int TWR_N  = sat0(T_WR);
  localparam int CL_N   = sat0(CAS_LAT - 1);
  localparam int RD_N   = sat0(BURST_LEN);
  localparam int TRFC_N = sat0(T_RFC - 1);
`ifdef SDRAM_AUTO_PRE_EN
  localparam int   TRP_N  = sat0(T_RP);
  localparam logic AP_BIT = 1'b1;
`else
  localparam int   TRP_N  = sat0(T_RP - 1);
  localparam logic AP_BIT = 1'b0;
`endif

  // Successor states with zero-length delay states folded away
  localparam logic [3:0] S_AFTER_PRE = (TRP_N > 0) ? W_TRP : W_IDLE;
`ifdef SDRAM_AUTO_PRE_EN
  localparam logic [3:0] S_CLOSE = S_AFTER_PRE;
`else
  localparam logic [3:0] S_CLOSE = W_PRE;
`endif
  localparam logic [3:0] S_AFTER_WD    = (TWR_N > 0) ? W_TWR : S_CLOSE;
  localparam logic [3:0] S_AFTER_WRITE = (WD_N > 0) ? W_WD : S_AFTER_WD;
  localparam logic [3:0] S_AFTER_CL    = (RD_N > 0) ? W_RD : S_CLOSE;
  localparam logic [3:0] S_AFTER_READ  = (CL_N > 0) ? W_CL : S_AFTER_CL;
  localparam logic [3:0] S_AFTER_AR    = (TRFC_N > 0) ? W_TRFC : W_IDLE;

  // Counter preload on entry to a delay state (counts down to 0)
  function automatic logic [7:0] load_for(input logic [3:0] s);
    case (s)
      W_TRCD:  return 8'(sat0(TRCD_N - 1));
      W_WD:    return 8'(sat0(WD_N - 1));
      W_TWR:   return 8'(sat0(TWR_N - 1));
      W_CL:    return 8'(sat0(CL_N - 1));
      W_RD:    return 8'(sat0(RD_N - 1));
      W_TRP:   return 8'(sat0(TRP_N - 1));
      W_TRFC:  return 8'(sat0(TRFC_N - 1));
      default: return 8'd0;
    endcase
  endfunction

  logic [3:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        op_wr_q, op_wr_d;
  logic [10:0] lat_q, lat_d;      // {bank, col} of the accepted request
  logic [3:0]  cmd_q, cmd_d;
  logic [1:0]  ba_q, ba_d;
  logic [12:0] addr_q, addr_d;
  logic        wr_ack_q, wr_ack_d;
  logic        rd_ack_q, rd_ack_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        ref_req_s;
  logic        ref_clr_s;
  logic        cnt_zero_s;

  assign ref_clr_s  = (state_d == W_AR);
  assign cnt_zero_s = (cnt_q == 8'd0);

  sdram_ref_timer #(
    .REF_INTERVAL (REF_INTERVAL)
  ) u_ref_timer (
    .clk     (clk_100m),
    .rst     (rst),
    .en      (bus.init_done),
    .clr     (ref_clr_s),
    .ref_req (ref_req_s)
  );

  // Next-state, arbitration and request latching
  always_comb begin
    state_d  = state_q;
    op_wr_d  = op_wr_q;
    lat_d    = lat_q;
    wr_ack_d = 1'b0;
    rd_ack_d = 1'b0;
    case (state_q)
      W_IDLE: begin
        if (!bus.init_done) begin
          state_d = W_IDLE;
        end else if (ref_req_s) begin
          state_d = W_AR;
        end else if (bus.wr_req) begin
          state_d  = W_ACTIVE;
          op_wr_d  = 1'b1;
          lat_d    = {bus.sys_addr[23:22], bus.sys_addr[8:0]};
          wr_ack_d = 1'b1;
        end else if (bus.rd_req) begin
          state_d  = W_ACTIVE;
          op_wr_d  = 1'b0;
          lat_d    = {bus.sys_addr[23:22], bus.sys_addr[8:0]};
          rd_ack_d = 1'b1;
        end else begin
          state_d = W_IDLE;
        end
      end
      W_ACTIVE: state_d = (TRCD_N > 0) ? W_TRCD : (op_wr_q ? W_WRITE : W_READ);
      W_TRCD:   state_d = cnt_zero_s ? (op_wr_q ? W_WRITE : W_READ) : W_TRCD;
      W_WRITE:  state_d = S_AFTER_WRITE;
      W_WD:     state_d = cnt_zero_s ? S_AFTER_WD : W_WD;
      W_TWR:    state_d = cnt_zero_s ? S_CLOSE : W_TWR;
      W_READ:   state_d = S_AFTER_READ;
      W_CL:     state_d = cnt_zero_s ? S_AFTER_CL : W_CL;
      W_RD:     state_d = cnt_zero_s ? S_CLOSE : W_RD;
      W_PRE:    state_d = S_AFTER_PRE;
      W_TRP:    state_d = cnt_zero_s ? W_IDLE : W_TRP;
      W_AR:     state_d = S_AFTER_AR;
      W_TRFC:   state_d = cnt_zero_s ? W_IDLE : W_TRFC;
      default:  state_d = W_IDLE;
    endcase
  end

  // Delay counter: preload on a state change, otherwise count down to 0
  always_comb begin
    if (state_d != state_q) begin
      cnt_d = load_for(state_d);
    end else if (!cnt_zero_s) begin
      cnt_d = cnt_q - 8'd1;
    end else begin
      cnt_d = 8'd0;
    end
  end

  // Pin values for the state being entered, so they register alongside it
  always_comb begin
    cmd_d  = CMD_NOP;
    ba_d   = 2'd0;
    addr_d = 13'd0;
    case (state_d)
      W_ACTIVE: begin
        cmd_d  = CMD_ACT;
        ba_d   = bus.sys_addr[23:22];
        addr_d = bus.sys_addr[21:9];
      end
      W_WRITE: begin
        cmd_d  = CMD_WRITE;
        ba_d   = lat_q[10:9];
        addr_d = {2'b00, AP_BIT, 1'b0, lat_q[8:0]};
      end
      W_READ: begin
        cmd_d  = CMD_READ;
        ba_d   = lat_q[10:9];
        addr_d = {2'b00, AP_BIT, 1'b0, lat_q[8:0]};
      end
      W_PRE: begin
        cmd_d  = CMD_PRE;
        addr_d = ADDR_PRE_ALL;
      end
      W_AR: begin
        cmd_d = CMD_AREF;
      end
      default: begin
        cmd_d = CMD_NOP;
      end
    endcase
    done_d = (state_d == W_IDLE) && (state_q != W_IDLE);
    busy_d = (state_d != W_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk_100m) begin
    if (rst) begin
      state_q  <= W_IDLE;
      cnt_q    <= 8'd0;
      op_wr_q  <= 1'b0;
      lat_q    <= 11'd0;
      cmd_q    <= CMD_NOP;
      ba_q     <= 2'd0;
      addr_q   <= 13'd0;
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_wr_q  <= op_wr_d;
      lat_q    <= lat_d;
      cmd_q    <= cmd_d;
      ba_q     <= ba_d;
      addr_q   <= addr_d;
      wr_ack_q <= wr_ack_d;
      rd_ack_q <= rd_ack_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.work_state = state_q;
  assign bus.sdram_cmd  = cmd_q;
  assign bus.sdram_ba   = ba_q;
  assign bus.sdram_addr = addr_q;
  assign bus.wr_ack     = wr_ack_q;
  assign bus.rd_ack     = rd_ack_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sdram_work_ctrl.sv
// Directed bench for sdram_work_ctrl (default parameters).
// Honours SDRAM_AUTO_PRE_EN for the expected close sequence.
module tb_sdram_work_ctrl;

  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RDC = 4'b0101,
                         WRC = 4'b0100, PRE = 4'b0010, AREF = 4'b0001;

`ifdef SDRAM_AUTO_PRE_EN
  localparam logic [3:0]  CLOSE_ST  = 4'd10;
  localparam logic [3:0]  CLOSE_CMD = 4'b0111;
  localparam logic [12:0] CLOSE_A   = 13'h0000;
  localparam logic [12:0] A10       = 13'h0400;
`else
  localparam logic [3:0]  CLOSE_ST  = 4'd9;
  localparam logic [3:0]  CLOSE_CMD = 4'b0010;
  localparam logic [12:0] CLOSE_A   = 13'h0400;
  localparam logic [12:0] A10       = 13'h0000;
`endif

  typedef struct {
    logic        wr;
    logic        rd;
    logic [23:0] addr;
    logic [3:0]  st;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] a;
    logic        wack;
    logic        rack;
    logic        done;
    logic        busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tv[$];

  sdram_work_ctrl_if bus ();

  sdram_work_ctrl dut (
    .clk_100m (clk),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic rd, input logic [23:0] addr,
                     input logic [3:0] st, input logic [3:0] cmd, input logic [1:0] ba,
                     input logic [12:0] a, input logic wack, input logic rack,
                     input logic done, input logic busy);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.st = st; v.cmd = cmd; v.ba = ba;
    v.a = a; v.wack = wack; v.rack = rack; v.done = done; v.busy = busy;
    tv.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    bus.init_done = 1'b1;
  endtask

  initial begin
    logic [23:0] wa;
    logic [23:0] ra;
    logic        aref_early;
    logic        found;
    logic        rd_done_seen;
    int          wacks;
    int          racks;
    int          n;

    wa = 24'h40_0A05;                    // bank 1, row 5, col 5
    ra = {2'd2, 13'h1ABC, 9'h0F3};       // bank 2, row 0x1ABC, col 0x0F3

    // write burst: ACT, TRCD, WRITE, WD x3, TWR x2, close, TRP, IDLE+done
    add(1'b1, 1'b0, wa, 4'd1, ACT,  2'd1, 13'h0005,       1'b1, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, wa, 4'd2, NOP,  2'd0, 13'h0000,       1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, wa, 4'd6, WRC,  2'd1, 13'h0005 | A10, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      add(1'b0, 1'b0, wa, 4'd7, NOP, 2'd0, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++)
      add(1'b0, 1'b0, wa, 4'd8, NOP, 2'd0, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, wa, CLOSE_ST, CLOSE_CMD, 2'd0, CLOSE_A, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, wa, 4'd10, NOP, 2'd0, 13'h0000,       1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, wa, 4'd0,  NOP, 2'd0, 13'h0000,       1'b0, 1'b0, 1'b1, 1'b0);
    // read burst: ACT, TRCD, READ, CL x2, RD x4, close, TRP, IDLE+done
    add(1'b0, 1'b1, ra, 4'd1, ACT,  2'd2, 13'h1ABC,       1'b0, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, ra, 4'd2, NOP,  2'd0, 13'h0000,       1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, ra, 4'd3, RDC,  2'd2, 13'h00F3 | A10, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++)
      add(1'b0, 1'b0, ra, 4'd4, NOP, 2'd0, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      add(1'b0, 1'b0, ra, 4'd5, NOP, 2'd0, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, ra, CLOSE_ST, CLOSE_CMD, 2'd0, CLOSE_A, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, ra, 4'd10, NOP, 2'd0, 13'h0000,       1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, ra, 4'd0,  NOP, 2'd0, 13'h0000,       1'b0, 1'b0, 1'b1, 1'b0);

    // reset state
    rst = 1'b1;
    bus.init_done = 1'b0;
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    bus.sys_addr = 24'h00_0000;
    step();
    step();
    chk("rst_state", {28'd0, bus.work_state}, 32'd0);
    chk("rst_cmd", {28'd0, bus.sdram_cmd}, {28'd0, NOP});
    chk("rst_ba_addr", {17'd0, bus.sdram_ba, bus.sdram_addr}, 32'd0);
    chk("rst_flags", {28'd0, bus.wr_ack, bus.rd_ack, bus.done, bus.busy}, 32'd0);

    // before init_done requests are ignored
    rst = 1'b0;
    bus.wr_req = 1'b1;
    bus.sys_addr = wa;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("noinit_%0d", i),
          {24'd0, bus.work_state, bus.sdram_cmd}, {24'd0, 4'd0, NOP});
      chk($sformatf("noinit_flags_%0d", i), {30'd0, bus.wr_ack, bus.busy}, 32'd0);
    end
    bus.wr_req = 1'b0;
    step();

    // table: write then read, cycle by cycle
    bus.init_done = 1'b1;
    foreach (tv[i]) begin
      bus.wr_req = tv[i].wr;
      bus.rd_req = tv[i].rd;
      bus.sys_addr = tv[i].addr;
      step();
      chk($sformatf("v%0d_state", i), {28'd0, bus.work_state}, {28'd0, tv[i].st});
      chk($sformatf("v%0d_cmd", i), {28'd0, bus.sdram_cmd}, {28'd0, tv[i].cmd});
      chk($sformatf("v%0d_ba", i), {30'd0, bus.sdram_ba}, {30'd0, tv[i].ba});
      chk($sformatf("v%0d_addr", i), {19'd0, bus.sdram_addr}, {19'd0, tv[i].a});
      chk($sformatf("v%0d_flags", i), {28'd0, bus.wr_ack, bus.rd_ack, bus.done, bus.busy},
          {28'd0, tv[i].wack, tv[i].rack, tv[i].done, tv[i].busy});
    end
    bus.rd_req = 1'b0;

    // refresh timing and priority: refresh > write > read
    do_reset();
    aref_early = 1'b0;
    for (int i = 1; i <= 779; i++) begin
      step();
      if (bus.sdram_cmd == AREF) aref_early = 1'b1;
    end
    chk("no_aref_before_interval", {31'd0, aref_early}, 32'd0);
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    bus.sys_addr = wa;
    step();
    chk("aref_at_780", {24'd0, bus.sdram_cmd, bus.work_state}, {24'd0, AREF, 4'd11});
    chk("aref_busy_noack", {29'd0, bus.busy, bus.wr_ack, bus.rd_ack}, {29'd0, 3'b100});
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("trfc_%0d", k), {24'd0, bus.work_state, 1'b0, bus.busy, bus.done, 1'b0},
          {24'd0, 4'd12, 4'b0100});
    end
    step();
    chk("aref_done_at_plus7", {27'd0, bus.work_state, bus.done}, {27'd0, 4'd0, 1'b1});
    step();
    chk("wr_after_ref", {26'd0, bus.wr_ack, bus.rd_ack, bus.sdram_cmd}, {26'd0, 2'b10, ACT});
    wacks = bus.wr_ack ? 1 : 0;
    racks = 0;
    bus.wr_req = 1'b0;
    rd_done_seen = 1'b0;
    n = 0;
    while (!rd_done_seen && n < 80) begin
      step();
      n++;
      if (bus.wr_ack) wacks++;
      if (bus.rd_ack) begin
        racks++;
        bus.rd_req = 1'b0;
      end
      if (bus.done && racks > 0) rd_done_seen = 1'b1;
    end
    chk("prio_rd_done_in_budget", {31'd0, rd_done_seen}, 32'd1);
    chk("prio_wr_ack_count", wacks, 32'd1);
    chk("prio_rd_ack_count", racks, 32'd1);
    bus.rd_req = 1'b0;

    // reset during the read capture window
    bus.rd_req = 1'b1;
    bus.sys_addr = ra;
    found = 1'b0;
    n = 0;
    while (!found && n < 30) begin
      step();
      n++;
      if (bus.rd_ack) bus.rd_req = 1'b0;
      if (bus.work_state == 4'd5) found = 1'b1;
    end
    chk("reached_rd", {31'd0, found}, 32'd1);
    bus.rd_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("midrst_state_cmd", {24'd0, bus.work_state, bus.sdram_cmd}, {24'd0, 4'd0, NOP});
    chk("midrst_flags", {13'd0, bus.busy, bus.done, bus.sdram_ba, bus.sdram_addr}, 32'd0);
    rst = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 900) begin
      step();
      n++;
      if (bus.sdram_cmd == AREF) found = 1'b1;
    end
    chk("aref_780_after_midrst", n, 32'd780);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
